// File: rtl/controle_cronometro.sv
// controle_cronometro: button conditioning, stopwatch control FSM and count-enable prescaler.
// Latency: a clean press is reflected on estado/level outputs/resetC DEBOUNCE_CYCLES+3 edges after first sample.
// Backpressure: none; commands are single-cycle pulses and every output is a free-running register.
//
// Ports:
//   clock, reset            - system clock, synchronous active-low reset
//   resetI/contarI/pausarI/pararI - raw asynchronous push buttons (active-high)
//   resetC                  - one-cycle clear pulse to the digit counters (held high during reset)
//   contarC/pausarC/pararC  - registered state levels (CONTANDO / PAUSADO / PARADO)
//   tick                    - one-cycle count enable, every TICK_DIV cycles while counting
//   estado                  - current FSM state
module controle_cronometro #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_DIV        = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       resetI,
    input  logic       contarI,
    input  logic       pausarI,
    input  logic       pararI,
    output logic       resetC,
    output logic       contarC,
    output logic       pausarC,
    output logic       pararC,
    output logic       tick,
    output logic [1:0] estado
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int TK_W = $clog2(TICK_DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);

    // Button bit positions inside the per-button vectors.
    localparam int B_ZERO   = 0;
    localparam int B_CONTAR = 1;
    localparam int B_PAUSAR = 2;
    localparam int B_PARAR  = 3;

    typedef enum logic [1:0] {
        ZERADO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSADO  = 2'd2,
        PARADO   = 2'd3
    } estado_t;

    logic [3:0]      btn_raw;
    logic [3:0]      sync1;
    logic [3:0]      sync2;
    logic [3:0]      lvl;      // debounced (accepted) level
    logic [3:0]      lvl_d;    // accepted level one cycle ago, for edge detection
    logic [3:0]      cmd;      // registered rising-edge command pulses
    logic [DB_W-1:0] db_cnt [4];

    estado_t         state;
    estado_t         state_nxt;
    logic [TK_W-1:0] presc;
    logic [TK_W-1:0] presc_nxt;
    logic            reset_nxt;
    logic            tick_nxt;

    assign btn_raw = {pararI, pausarI, contarI, resetI};
    assign estado  = state;

    // Synchroniser, debouncer and edge detector for all four buttons.
    // The command pulse is registered so the FSM sees a clean one-cycle input.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            lvl_d <= '0;
            cmd   <= '0;
            for (int b = 0; b < 4; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            lvl_d <= lvl;
            cmd   <= lvl & ~lvl_d;
            for (int b = 0; b < 4; b++) begin
                if (sync2[b] == lvl[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    // DEBOUNCE_CYCLES consecutive disagreeing samples: accept the new level.
                    lvl[b]    <= ~lvl[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

    // Next-state, clear pulse and prescaler. Priority chain means lower
    // commands arriving in the same cycle are simply dropped.
    always_comb begin
        state_nxt = state;
        reset_nxt = 1'b0;
        presc_nxt = presc;
        tick_nxt  = 1'b0;

        if (cmd[B_ZERO]) begin
            state_nxt = ZERADO;
            reset_nxt = 1'b1;
        end else if (cmd[B_PARAR]) begin
            if (state == CONTANDO || state == PAUSADO) begin
                state_nxt = PARADO;
            end
        end else if (cmd[B_PAUSAR]) begin
            if (state == CONTANDO) begin
                state_nxt = PAUSADO;
            end else if (state == PAUSADO) begin
                state_nxt = CONTANDO;
            end
        end else if (cmd[B_CONTAR]) begin
            if (state == ZERADO || state == PAUSADO) begin
                state_nxt = CONTANDO;
            end
        end

        // Prescaler keeps its partial period across pause/stop so a resume
        // finishes the interrupted millisecond.
        case (state)
            CONTANDO: begin
                if (presc == TK_LAST) begin
                    presc_nxt = '0;
                    tick_nxt  = 1'b1;
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end
            ZERADO:  presc_nxt = '0;
            default: presc_nxt = presc;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= ZERADO;
            presc   <= '0;
            resetC  <= 1'b1;   // keep the counters cleared while in reset
            contarC <= 1'b0;
            pausarC <= 1'b0;
            pararC  <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            resetC  <= reset_nxt;
            contarC <= (state_nxt == CONTANDO);
            pausarC <= (state_nxt == PAUSADO);
            pararC  <= (state_nxt == PARADO);
            tick    <= tick_nxt;
        end
    end

endmodule

// File: doc/controle_cronometro.md
# controle_cronometro

Control sequencer for the stopwatch datapath. It conditions the four raw push-button inputs with synchronisation, debounce and rising-edge detection. A four-state FSM decides whether the cascaded digit counters clear, count, pause or freeze. It also generates the 1 ms count-enable tick that drives the least-significant counter, and it sits between the board pins and the counter chain.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a button change; must be ≥ 2.
- TICK_DIV, 50000: clock cycles per `tick` pulse while counting; must be ≥ 2.

Ports:
- `clock` in 1: single system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low system reset.
- `resetI` in 1: raw "zero" button, active-high, asynchronous to `clock`.
- `contarI` in 1: raw "start/resume" button, active-high, asynchronous.
- `pausarI` in 1: raw "pause/resume toggle" button, active-high, asynchronous.
- `pararI` in 1: raw "stop/freeze" button, active-high, asynchronous.
- `resetC` out 1: registered clear command to the counters (pulse).
- `contarC` out 1: registered level, 1 in CONTANDO.
- `pausarC` out 1: registered level, 1 in PAUSADO.
- `pararC` out 1: registered level, 1 in PARADO.
- `tick` out 1: registered single-cycle count-enable pulse.
- `estado` out 2: current state (ZERADO=0, CONTANDO=1, PAUSADO=2, PARADO=3).

## Operation
- Each button passes through a 2-flop synchroniser, then a debouncer.
- The debouncer holds an accepted level and a counter of width clog2(DEBOUNCE_CYCLES).
  - The counter increments while the synchronised level differs from the accepted level.
  - It resets to 0 whenever the two are equal.
  - When it reaches DEBOUNCE_CYCLES-1 with the levels still differing, the accepted level flips and the counter clears.
- A rising edge of an accepted level produces one internal command pulse. Falling edges produce nothing.
- Command priority within one cycle: zero > parar > pausar > contar. Only the highest-priority pulse is acted on; the others are dropped.
- FSM transitions:
  - ZERADO: contar → CONTANDO. Pausar and parar are ignored. Zero stays in ZERADO and re-pulses `resetC`.
  - CONTANDO: pausar → PAUSADO; parar → PARADO; zero → ZERADO; contar is ignored.
  - PAUSADO: contar or pausar → CONTANDO; parar → PARADO; zero → ZERADO.
  - PARADO: zero → ZERADO; everything else is ignored, so the display stays frozen.
- `resetC` is 1 for exactly one cycle on every cycle where the zero command is accepted, in any state.
- Prescaler (width clog2(TICK_DIV)):
  - Increments only in CONTANDO.
  - When it equals TICK_DIV-1, `tick`=1 for that cycle and the prescaler wraps to 0.
  - It holds its value in PAUSADO and PARADO, so a resume completes the partial period.
  - It is forced to 0 in ZERADO.
- `tick` is 0 in every state other than CONTANDO.

## Timing
- Reset values, while `reset`=0 at a clock edge:
  - State is ZERADO; `estado`=0.
  - `resetC`=1, so the counters clear during reset.
  - `contarC`=`pausarC`=`pararC`=`tick`=0.
  - Synchronisers, accepted levels, debounce counters and prescaler are all 0.
- `resetC` returns to 0 on the first edge after `reset` goes high. Reset asserted mid-operation aborts everything on the next edge, with no partial state kept.
- Button latency:
  - Take edge 0 as the first edge at which the raw input is sampled 1, and assume the input is held stable.
  - `estado` and the level outputs reflect the new state at edge DEBOUNCE_CYCLES+3.
  - `resetC` pulses at that same edge.
- Debounce filtering:
  - A synchronised glitch shorter than DEBOUNCE_CYCLES cycles produces no command.
  - A button held high for any time produces exactly one command.
  - A second command requires a release accepted by the debouncer, followed by a new press.
- Tick timing:
  - After entry to CONTANDO from ZERADO, the first `tick` occurs TICK_DIV edges after the edge where `contarC` rises.
  - Subsequent ticks are spaced exactly TICK_DIV cycles apart.
- Level outputs are mutually exclusive and all 0 in ZERADO.

## Test plan
- With DEBOUNCE_CYCLES=4 and TICK_DIV=5: release reset, then hold `contarI` high from edge 0.
  - `contarC`=1 and `estado`=1 at edge 7.
  - `tick` is high on edges 12, 17, 22.
- Pause mid-period (prescaler at 2), hold for 20 cycles, then resume:
  - `tick` stays 0 while paused.
  - The first tick after resume is 3 cycles after `contarC` returns to 1.
- Pulse `pausarI` for 3 cycles, then for 2 cycles (DEBOUNCE_CYCLES=4):
  - No state change.
  - A 10-cycle press with 1-cycle bounces at its start yields exactly one transition.
- Assert `pararI` and `pausarI` on the same cycle in CONTANDO:
  - The block goes to PARADO.
  - A later `contarI` or `pausarI` is ignored.
  - `resetI` then gives `estado`=0 and one `resetC` pulse.
- In ZERADO, press `pausarI` and `pararI` and `estado` stays 0. Press `resetI` in ZERADO and `resetC` pulses for one cycle.
- Drive `reset`=0 for 1 cycle while counting:
  - The next edge shows `estado`=0, `resetC`=1, `tick`=0.
  - After release, `resetC`=0 and the prescaler restarts from 0.
